// File: rtl/swipt_pkg.sv
// Shared types, constants and helpers for the SWIPT gate driver.
package swipt_pkg;

  typedef enum logic [2:0] {
    D_IDLE,
    D_HI,
    D_DT1,
    D_LO,
    D_DT2
  } drive_e;

  localparam int unsigned CLK_HZ = 100_000_000;

  function automatic logic [32:0] abs_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[32] ? (~d + 33'd1) : d;
  endfunction

endpackage

// File: rtl/swipt_gate_drive_if.sv
// Control and status bundle between the PLL side and the gate driver.
interface swipt_gate_drive_if;
  logic        en;
  logic [31:0] f_in;
  logic        f_valid;
  logic        busy;
  logic [31:0] half_cnt;
  logic        gate_hi;
  logic        gate_lo;
  logic        prd_tick;
  logic        freq_rdy;

  modport master (
    output en, f_in, f_valid,
    input  busy, half_cnt, gate_hi, gate_lo, prd_tick, freq_rdy
  );

  modport slave (
    input  en, f_in, f_valid,
    output busy, half_cnt, gate_hi, gate_lo, prd_tick, freq_rdy
  );
endinterface

// File: rtl/udiv32_seq.sv
// Restoring 32/32 unsigned divider, one quotient bit per cycle.
module udiv32_seq (
  input  logic        clk,
  input  logic        nrst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q
);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic [32:0] sh;
  logic [32:0] df;

  always_comb begin
    sh = {rem, quo[31]};
    df = sh - {1'b0, dvs};
  end

  // cnt==32 marks the extra cycle that presents the finished quotient
  assign done = busy && (cnt == 6'd32);
  assign q    = quo;

  always_ff @(posedge clk) begin
    if (nrst || abort) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= a;
      dvs  <= b;
    end else if (busy) begin
      if (cnt == 6'd32) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 6'd1;
        if (!df[32]) begin
          rem <= df[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= sh[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/swipt_gate_drive.sv
// PLL frequency word to complementary dead-timed gate drives with lock flag.
module swipt_gate_drive #(
  parameter int unsigned CLK_HZ   = swipt_pkg::CLK_HZ,
  parameter int unsigned F_MIN    = 30_000,
  parameter int unsigned F_MAX    = 50_000,
  parameter int unsigned DEAD_CYC = 20,
  parameter int unsigned LOCK_TOL = 4,
  parameter int unsigned LOCK_N   = 8
) (
  input logic clk,
  input logic nrst,
  swipt_gate_drive_if.slave bus
);
  import swipt_pkg::*;

  localparam logic [2:0] IDLE = D_IDLE;
  localparam logic [2:0] HI   = D_HI;
  localparam logic [2:0] DT1  = D_DT1;
  localparam logic [2:0] LO   = D_LO;
  localparam logic [2:0] DT2  = D_DT2;

  localparam logic [31:0] FMN = 32'(F_MIN);
  localparam logic [31:0] FMX = 32'(F_MAX);
  localparam logic [31:0] DC  = 32'(DEAD_CYC);
  localparam logic [31:0] LN  = 32'(LOCK_N);
  localparam logic [32:0] TOL = 33'(LOCK_TOL);
  localparam logic [31:0] DVD = 32'(CLK_HZ);

  logic [2:0]  state;
  logic [31:0] fc, pend, shadow, half, ph, lock, dq, div_b, nh;
  logic        pend_v, shadow_v, dbusy, ddone, acc, start, upd, prd;

  assign fc = (bus.f_in < FMN) ? FMN :
              (bus.f_in > FMX) ? FMX : bus.f_in;

  assign acc   = bus.en && bus.f_valid;
  // A fresh strobe at completion wins over the older pending value
  assign start = bus.en && ((acc && !dbusy) ||
                 (ddone && (acc || pend_v)));
  assign div_b = (acc ? fc : pend) << 1;

  udiv32_seq u_div (
    .clk   (clk),
    .nrst  (nrst),
    .abort (!bus.en),
    .start (start),
    .a     (DVD),
    .b     (div_b),
    .busy  (dbusy),
    .done  (ddone),
    .q     (dq)
  );

  assign upd = (state == DT2) && (ph == '0) &&
               (ddone || shadow_v);
  assign nh  = ddone ? dq : shadow;

  always_ff @(posedge clk) begin
    if (nrst || !bus.en) begin
      pend_v <= 1'b0;
      if (nrst) pend <= '0;
    end else if (acc && dbusy && !ddone) begin
      pend   <= fc;
      pend_v <= 1'b1;
    end else if (ddone) begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst || !bus.en) begin
      shadow_v <= 1'b0;
      if (nrst) shadow <= '0;
    end else if (ddone && state != IDLE && !upd) begin
      shadow   <= dq;
      shadow_v <= 1'b1;
    end else if (upd) begin
      shadow_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
      half  <= '0;
      ph    <= '0;
      lock  <= '0;
      prd   <= 1'b0;
    end else if (!bus.en) begin
      state <= IDLE;
      ph    <= '0;
      lock  <= '0;
      prd   <= 1'b0;
    end else begin
      prd <= 1'b0;
      case (state)
        IDLE: if (ddone) begin
          state <= HI;
          half  <= dq;
          ph    <= dq - DC - 32'd1;
          lock  <= '0;
          prd   <= 1'b1;
        end
        HI: if (ph == '0) begin
          state <= DT1;
          ph    <= DC - 32'd1;
        end else ph <= ph - 32'd1;
        DT1: if (ph == '0) begin
          state <= LO;
          ph    <= half - DC - 32'd1;
        end else ph <= ph - 32'd1;
        LO: if (ph == '0) begin
          state <= DT2;
          ph    <= DC - 32'd1;
        end else ph <= ph - 32'd1;
        DT2: if (ph == '0) begin
          state <= HI;
          prd   <= 1'b1;
          ph    <= (upd ? nh : half) - DC - 32'd1;
          if (upd) begin
            half <= nh;
            if (abs_diff(nh, half) <= TOL)
              lock <= (lock == LN) ? lock : lock + 32'd1;
            else
              lock <= '0;
          end
        end else ph <= ph - 32'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = dbusy;
  assign bus.half_cnt = half;
  assign bus.gate_hi  = (state == HI);
  assign bus.gate_lo  = (state == LO);
  assign bus.prd_tick = prd;
  assign bus.freq_rdy = (lock == LN);

endmodule

// File: tb/tb_swipt_gate_drive.sv
// Directed bench with a timeline model of the gate driver.
module tb_swipt_gate_drive;

  localparam int CLKHZ = 100_000_000;
  localparam int FMIN  = 30_000;
  localparam int FMAX  = 50_000;
  localparam int D     = 20;
  localparam int TOL   = 4;
  localparam int LN    = 8;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  swipt_gate_drive_if bus ();

  swipt_gate_drive dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;
  int cyc = 0;

  // Model: divider as an acceptance time, drive as a period start + half
  bit dv_on, pd_v, sh_v, run, seen;
  int dv_t0, dv_val, pd_f, sh_val, ps, H, lk;

  function automatic int clampf(input int unsigned f);
    if (f < FMIN) return FMIN;
    if (f > FMAX) return FMAX;
    return int'(f);
  endfunction

  task automatic apply(input int v);
    int d;
    d = (v > H) ? v - H : H - v;
    if (d <= TOL) lk = (lk < LN) ? lk + 1 : LN;
    else lk = 0;
    H = v;
  endtask

  always @(posedge clk) begin : model
    bit done, used;
    int n, gv, m, p;
    bit eb, eh, el, ep, er;
    n = cyc;
    if (nrst) begin
      dv_on = 0; pd_v = 0; sh_v = 0; run = 0;
      H = 0; lk = 0; seen = 1;
    end else if (!bus.en) begin
      dv_on = 0; pd_v = 0; sh_v = 0; run = 0; lk = 0;
    end else begin
      done = dv_on && (n == dv_t0 + 33);
      gv = dv_val;
      used = 0;
      if (done) dv_on = 0;
      if (bus.f_valid) begin
        if (!dv_on) begin
          dv_on = 1; dv_t0 = n; pd_v = 0;
          dv_val = CLKHZ / (2 * clampf(bus.f_in));
        end else begin
          pd_v = 1; pd_f = clampf(bus.f_in);
        end
      end else if (!dv_on && pd_v) begin
        dv_on = 1; dv_t0 = n; pd_v = 0;
        dv_val = CLKHZ / (2 * pd_f);
      end
      if (!run) begin
        if (done) begin
          run = 1; ps = n + 1; H = gv; lk = 0; used = 1;
        end
      end else if (n + 1 - ps == 2 * H) begin
        ps = n + 1;
        if (done) begin apply(gv); used = 1; sh_v = 0; end
        else if (sh_v) begin apply(sh_val); sh_v = 0; end
      end
      if (done && !used) begin sh_v = 1; sh_val = gv; end
    end
    cyc++;
    #1;
    if (seen) begin
      m  = cyc;
      p  = m - ps;
      eb = dv_on && m > dv_t0 && m <= dv_t0 + 33;
      eh = run && p >= 0 && p < H - D;
      el = run && p >= H && p < 2 * H - D;
      ep = run && p == 0;
      er = (lk == LN);
      vectors++;
      if (bus.busy !== eb || bus.half_cnt !== 32'(H) ||
          bus.gate_hi !== eh || bus.gate_lo !== el ||
          bus.prd_tick !== ep || bus.freq_rdy !== er) begin
        miscompares++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL model cyc=%0d got b%0b h%0d hi%0b lo%0b t%0b r%0b exp b%0b h%0d hi%0b lo%0b t%0b r%0b",
            m, bus.busy, bus.half_cnt, bus.gate_hi, bus.gate_lo,
            bus.prd_tick, bus.freq_rdy, eb, H, eh, el, ep, er);
        end
      end
      vectors++;
      if (bus.gate_hi && bus.gate_lo) begin
        miscompares++;
        $display("FAIL overlap cyc=%0d got hi=1 lo=1 expected not both", m);
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit sig(input int w);
    case (w)
      0: return bus.prd_tick;
      1: return !bus.busy;
      2: return bus.gate_hi;
      default: return bus.gate_lo;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm);
    int k;
    k = 0;
    while (!sig(w) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (!sig(w)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout %s: got no event expected within 4000 cycles", nm);
    end
  endtask

  task automatic strobe(input int unsigned f);
    @(negedge clk);
    bus.f_in = f;
    bus.f_valid = 1'b1;
    @(negedge clk);
    bus.f_valid = 1'b0;
  endtask

  task automatic settle(input int unsigned f, input int exp, input string nm);
    @(negedge clk);
    strobe(f);
    wait_for(1, "busy_low");
    wait_for(0, "tick");
    check(nm, bus.half_cnt, exp);
    @(negedge clk);
  endtask

  int unsigned lockf [8] = '{42100, 42200, 42100, 42000,
                             41900, 42000, 42100, 42200};
  int k, t1, t2, t3;

  initial begin
    nrst = 1'b1;
    bus.en = 1'b0;
    bus.f_in = '0;
    bus.f_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_half", bus.half_cnt, 0);
    check("rst_gates", {bus.gate_hi, bus.gate_lo}, 0);
    check("rst_tick_rdy", {bus.prd_tick, bus.freq_rdy}, 0);
    nrst = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;

    strobe(40000);
    k = 0;
    while (bus.busy && k < 100) begin k++; @(negedge clk); end
    check("busy_len", k, 33);
    check("half_first", bus.half_cnt, 1250);
    check("hi_first", {bus.gate_hi, bus.prd_tick}, 2'b11);
    k = 0;
    while (bus.gate_hi && k < 5000) begin k++; @(negedge clk); end
    check("hi_len", k, 1230);
    k = 0;
    while (!bus.gate_lo && k < 5000) begin k++; @(negedge clk); end
    check("dead_len", k, 20);
    k = 0;
    while (bus.gate_lo && k < 5000) begin k++; @(negedge clk); end
    check("lo_len", k, 1230);
    wait_for(0, "tick_a");
    t1 = cyc;
    @(negedge clk);
    wait_for(0, "tick_b");
    check("period_1250", cyc - t1, 2500);

    settle(100000, 1000, "clamp_hi");
    settle(10, 1666, "clamp_lo");
    settle(40000, 1250, "back_1250");

    wait_for(0, "tick_c");
    t1 = cyc;
    repeat (100) @(negedge clk);
    strobe(41000);
    wait_for(0, "tick_d");
    t2 = cyc;
    check("mid_hi_old", t2 - t1, 2500);
    check("mid_hi_new", bus.half_cnt, 1219);
    @(negedge clk);
    wait_for(0, "tick_e");
    t3 = cyc;
    check("period_1219", t3 - t2, 2438);

    @(negedge clk);
    strobe(40000);
    repeat (5) @(negedge clk);
    strobe(45000);
    repeat (5) @(negedge clk);
    strobe(42000);
    wait_for(1, "busy_low_pend");
    wait_for(0, "tick_f");
    @(negedge clk);
    wait_for(0, "tick_g");
    check("pend_final", bus.half_cnt, 1190);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      strobe(lockf[i]);
      wait_for(1, "busy_low_lock");
      wait_for(0, "tick_lock");
      check("lock_rdy", bus.freq_rdy, (i == 7));
      @(negedge clk);
    end
    strobe(41876);
    wait_for(1, "busy_low_jump");
    wait_for(0, "tick_jump");
    check("jump_half", bus.half_cnt, 1194);
    check("jump_rdy", bus.freq_rdy, 0);

    wait_for(3, "lo_rise");
    repeat (50) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    check("endrop_gates", {bus.gate_hi, bus.gate_lo}, 0);
    check("endrop_busy_rdy", {bus.busy, bus.freq_rdy}, 0);
    check("endrop_half", bus.half_cnt, 1194);
    strobe(30000);
    repeat (3) @(negedge clk);
    check("en0_ignored", bus.busy, 0);

    bus.en = 1'b1;
    strobe(40000);
    repeat (10) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
    check("rstdiv_busy", bus.busy, 0);
    check("rstdiv_gates", {bus.gate_hi, bus.gate_lo}, 0);
    check("rstdiv_half_rdy", {bus.half_cnt, bus.freq_rdy}, 0);
    repeat (5) @(negedge clk);
    strobe(50000);
    wait_for(1, "busy_low_end");
    check("restart_half", bus.half_cnt, 1000);
    repeat (100) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
